// File: rtl/dmem_access.sv
// dmem_access: MA-stage load/store unit with memory handshake, lane steering and pipeline stall
module dmem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        MemSize,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata_raw,
    output logic [2:0]        MemSize_out,
    output logic              done,
    output logic              access_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ready,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t state;
    logic [1:0] lane;
    logic [2:0] size_r;
    logic op, illegal, is_half, is_half_r;
    logic [3:0] be;
    logic [31:0] wd, shifted, aligned;
    always_comb begin
        op = req_valid && (mem_read || mem_write);
        is_half = MemSize == 3'd1 || MemSize == 3'd4;
        is_half_r = size_r == 3'd1 || size_r == 3'd4;
        illegal = (mem_read && mem_write) || MemSize > 3'd4 ||
                  (mem_write && (MemSize == 3'd3 || MemSize == 3'd4)) ||
                  (is_half && addr[0]) || (MemSize == 3'd2 && addr[1:0] != 2'b00);
        be = MemSize == 3'd2 ? 4'b1111 :
             is_half ? 4'b0011 << {addr[1], 1'b0} : 4'b0001 << addr[1:0];
        wd = !mem_write ? 32'h0 :
             MemSize == 3'd0 ? {4{wdata[7:0]}} :
             MemSize == 3'd1 ? {2{wdata[15:0]}} : wdata;
        shifted = dmem_rdata >> {lane, 3'b000};
        aligned = size_r == 3'd2 ? dmem_rdata :
                  is_half_r ? {16'h0, shifted[15:0]} : {24'h0, shifted[7:0]};
        stall = (state == IDLE && op) || state == REQ || state == RESP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lane <= 2'b00;
            size_r <= 3'b000;
            done <= 1'b0;
            access_err <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we <= 1'b0;
            dmem_addr <= '0;
            dmem_be <= 4'b0000;
            dmem_wdata <= 32'h0;
            rdata_raw <= 32'h0;
            MemSize_out <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    access_err <= 1'b0;
                    if (op) begin
                        lane <= addr[1:0];
                        size_r <= MemSize;
                        if (illegal) begin
                            state <= DONE;
                            done <= 1'b1;
                            access_err <= 1'b1;
                            rdata_raw <= 32'h0;
                            MemSize_out <= MemSize;
                        end else begin
                            state <= REQ;
                            dmem_req <= 1'b1;
                            dmem_we <= mem_write;
                            dmem_addr <= {addr[ADDR_W-1:2], 2'b00};
                            dmem_be <= be;
                            dmem_wdata <= wd;
                        end
                    end
                end
                REQ: if (dmem_ready) begin
                    dmem_req <= 1'b0;
                    state <= dmem_we ? DONE : RESP;
                    if (dmem_we) begin
                        done <= 1'b1;
                        rdata_raw <= 32'h0;
                        MemSize_out <= size_r;
                    end
                end
                RESP: if (dmem_rvalid) begin
                    state <= DONE;
                    done <= 1'b1;
                    rdata_raw <= aligned;
                    MemSize_out <= size_r;
                end
                DONE: begin
                    state <= IDLE;
                    done <= 1'b0;
                    access_err <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: vector table and scoreboard bench for dmem_access
module tb_dmem_access;
    logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0] MemSize = 3'd0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic stall, done, access_err, dmem_req, dmem_we;
    logic [31:0] rdata_raw, dmem_addr, dmem_wdata;
    logic [2:0] MemSize_out;
    logic [3:0] dmem_be;
    logic dmem_ready = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    int checks = 0, errors = 0;
    typedef struct {
        logic rd, wr;
        logic [2:0] sz;
        logic [31:0] addr, wd, rdata;
        int rw, vw;
        logic err;
        logic [3:0] be;
        logic [31:0] dwd, rraw;
    } vec_t;
    vec_t vecs[16];
    vec_t sb[$];
    dmem_access #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
        .MemSize(MemSize), .addr(addr), .wdata(wdata), .stall(stall), .rdata_raw(rdata_raw),
        .MemSize_out(MemSize_out), .done(done), .access_err(access_err), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, " stall"}, {31'h0, stall}, 32'h0);
        chk({nm, " done"}, {31'h0, done}, 32'h0);
        chk({nm, " err"}, {31'h0, access_err}, 32'h0);
        chk({nm, " req"}, {31'h0, dmem_req}, 32'h0);
        chk({nm, " we"}, {31'h0, dmem_we}, 32'h0);
        chk({nm, " addr"}, dmem_addr, 32'h0);
        chk({nm, " be"}, {28'h0, dmem_be}, 32'h0);
        chk({nm, " wdata"}, dmem_wdata, 32'h0);
        chk({nm, " rdata_raw"}, rdata_raw, 32'h0);
        chk({nm, " MemSize_out"}, {29'h0, MemSize_out}, 32'h0);
    endtask
    task automatic do_op(input vec_t v, input string nm);
        int stalls = 0, acc = 0, rwl = v.rw, vwl = v.vw, exp_st;
        bit pend = 0, seen = 0, stable = 1, fin = 0;
        logic [31:0] a0 = 0, w0 = 0;
        logic [3:0] b0 = 0;
        logic we0 = 0;
        vec_t e;
        @(negedge clk);
        req_valid = 1; mem_read = v.rd; mem_write = v.wr; MemSize = v.sz;
        addr = v.addr; wdata = v.wd; dmem_rdata = v.rdata;
        sb.push_back(v);
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            dmem_ready = 0;
            dmem_rvalid = 0;
            if (pend) begin
                if (vwl > 0) vwl--;
                else begin
                    dmem_rvalid = 1;
                    pend = 0;
                end
            end
            if (dmem_req) begin
                if (!seen) begin
                    a0 = dmem_addr; w0 = dmem_wdata; b0 = dmem_be; we0 = dmem_we;
                end else if (a0 !== dmem_addr || w0 !== dmem_wdata || b0 !== dmem_be || we0 !== dmem_we)
                    stable = 0;
                seen = 1;
                if (rwl > 0) rwl--;
                else begin
                    dmem_ready = 1;
                    acc++;
                    pend = !dmem_we;
                    chk({nm, " dmem_be"}, {28'h0, dmem_be}, {28'h0, v.be});
                    chk({nm, " dmem_addr"}, dmem_addr, v.addr & 32'hFFFF_FFFC);
                    chk({nm, " dmem_wdata"}, dmem_wdata, v.dwd);
                    chk({nm, " dmem_we"}, {31'h0, dmem_we}, {31'h0, v.wr});
                    chk({nm, " req stable"}, {31'h0, stable}, 32'h1);
                end
            end
            #1;
            if (cyc == 0) chk({nm, " no req in IDLE"}, {31'h0, dmem_req}, 32'h0);
            if (stall) stalls++;
            if (done) begin
                fin = 1;
                if (sb.size() == 0) chk({nm, " unexpected done"}, 32'h1, 32'h0);
                else begin
                    e = sb.pop_front();
                    exp_st = e.err ? 1 : e.wr ? 2 + e.rw : 3 + e.rw + e.vw;
                    chk({nm, " stall in DONE"}, {31'h0, stall}, 32'h0);
                    chk({nm, " stall cycles"}, stalls, exp_st);
                    chk({nm, " requests"}, acc, e.err ? 0 : 1);
                    chk({nm, " access_err"}, {31'h0, access_err}, {31'h0, e.err});
                    chk({nm, " rdata_raw"}, rdata_raw, e.rraw);
                    chk({nm, " MemSize_out"}, {29'h0, MemSize_out}, {29'h0, e.sz});
                end
            end
        end
        if (!fin) chk({nm, " done timeout"}, 32'h0, 32'h1);
        dmem_ready = 0;
        dmem_rvalid = 0;
    endtask
    initial begin
        //            rd wr sz    addr          wd            rdata         rw vw err be       dwd           rraw
        vecs[0]  = '{1, 0, 3'd0, 32'h0000_1003, 32'h0,        32'h80AA_BBCC, 0, 0, 0, 4'b1000, 32'h0,        32'h0000_0080};
        vecs[1]  = '{0, 1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        0, 0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[2]  = '{1, 0, 3'd4, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 3, 2, 0, 4'b0011, 32'h0,        32'h0000_BEEF};
        vecs[3]  = '{1, 0, 3'd2, 32'h0000_0006, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0};
        vecs[4]  = '{0, 1, 3'd3, 32'h0000_0000, 32'h5555_5555, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0};
        vecs[5]  = '{1, 1, 3'd2, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0};
        vecs[6]  = '{1, 0, 3'd2, 32'h0000_0100, 32'h0,        32'h1234_5678, 0, 1, 0, 4'b1111, 32'h0,        32'h1234_5678};
        vecs[7]  = '{1, 0, 3'd1, 32'h0000_0102, 32'h0,        32'hCAFE_1234, 0, 0, 0, 4'b1100, 32'h0,        32'h0000_CAFE};
        vecs[8]  = '{1, 0, 3'd3, 32'h0000_0101, 32'h0,        32'h1122_3344, 1, 0, 0, 4'b0010, 32'h0,        32'h0000_0033};
        vecs[9]  = '{0, 1, 3'd2, 32'h0000_0040, 32'hA5A5_1234, 32'h0,        0, 0, 0, 4'b1111, 32'hA5A5_1234, 32'h0};
        vecs[10] = '{1, 0, 3'd2, 32'h0000_0040, 32'h0,        32'hA5A5_1234, 0, 0, 0, 4'b1111, 32'h0,        32'hA5A5_1234};
        vecs[11] = '{0, 1, 3'd0, 32'h0000_0041, 32'h0000_00EE, 32'h0,        1, 0, 0, 4'b0010, 32'hEEEE_EEEE, 32'h0};
        vecs[12] = '{1, 0, 3'd1, 32'h0000_0001, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1, 0, 3'd5, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0};
        vecs[14] = '{0, 1, 3'd4, 32'h0000_0002, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0};
        vecs[15] = '{1, 0, 3'd0, 32'h0000_0000, 32'h0,        32'h0000_00FF, 0, 0, 0, 4'b0001, 32'h0,        32'h0000_00FF};
        repeat (2) @(negedge clk);
        #1 chk_zero("reset");
        rst = 0;
        for (int i = 0; i < 16; i++) do_op(vecs[i], $sformatf("op%0d", i));
        @(negedge clk);
        req_valid = 0;
        // drive a word load into RESP, then reset with the response still outstanding
        @(negedge clk);
        req_valid = 1; mem_read = 1; mem_write = 0; MemSize = 3'd2; addr = 32'h200;
        @(negedge clk);
        #1 chk("mid req asserted", {31'h0, dmem_req}, 32'h1);
        dmem_ready = 1;
        @(negedge clk);
        dmem_ready = 0;
        #1 chk("mid stall in RESP", {31'h0, stall}, 32'h1);
        rst = 1;
        req_valid = 0;
        @(negedge clk);
        rst = 0;
        dmem_rvalid = 1;
        dmem_rdata = 32'h7777_7777;
        #1 chk_zero("mid reset");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dmem_rvalid = 0;
            #1 chk($sformatf("post reset quiet %0d", i), {30'h0, done, dmem_req}, 32'h0);
        end
        do_op(vecs[0], "after reset");
        @(negedge clk);
        req_valid = 0;
        chk("scoreboard empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
